// File: rtl/sort_pkg.sv
// Shared types and constants for the selection-sort visualiser engine.
package sort_pkg;

  localparam int unsigned SwapCntW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StSwap,
    StDone
  } sort_state_e;

endpackage

// File: rtl/step_timer.sv
// Step tick generator: free-running divider in auto mode, pass-through of step otherwise.
module step_timer #(
  parameter int unsigned DELAY = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic auto_run,
  input  logic step,
  output logic tick
);

  localparam int unsigned CntW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DELAY - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  assign at_max = (cnt_q == CntMax);
  assign tick   = auto_run ? at_max : step;

  // The count is held (not cleared) while in step mode so auto mode resumes in phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (auto_run) begin
      cnt_d = at_max ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/select_sort_engine.sv
// Selection sort over N bars, one compare or exchange per tick, with display indices.
module select_sort_engine
  import sort_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned W     = 7,
  parameter int unsigned DELAY = 50000000,
  parameter int unsigned IW    = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [N*W-1:0]      in_data,
  input  logic                start,
  input  logic                desc,
  input  logic                auto_run,
  input  logic                step,
  output logic [N*W-1:0]      heights,
  output logic [IW-1:0]       cur_i,
  output logic [IW-1:0]       cur_j,
  output logic [IW-1:0]       min_idx,
  output logic                busy,
  output logic                done,
  output logic                swap_pulse,
  output logic [SwapCntW-1:0] swap_count
);

  sort_state_e         state_q, state_d;
  logic [W-1:0]        heights_q [N];
  logic [W-1:0]        heights_d [N];
  logic [IW-1:0]       cur_i_q, cur_i_d, cur_j_q, cur_j_d, min_idx_q, min_idx_d;
  logic [SwapCntW-1:0] swap_count_q, swap_count_d;
  logic                desc_q, desc_d, busy_q, busy_d, done_q, done_d;
  logic                swap_pulse_q, swap_pulse_d;
  logic                tick, accept_start, better;
  logic [W-1:0]        h_j, h_min;

  assign accept_start = ((state_q == StIdle) || (state_q == StDone)) && start && !load;

  step_timer #(
    .DELAY(DELAY)
  ) u_step_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept_start),
    .auto_run(auto_run),
    .step    (step),
    .tick    (tick)
  );

  assign h_j    = heights_q[cur_j_q];
  assign h_min  = heights_q[min_idx_q];
  // Strict comparisons keep the first of equal keys as the running extreme.
  assign better = desc_q ? (h_j > h_min) : (h_j < h_min);

  always_comb begin
    state_d      = state_q;
    heights_d    = heights_q;
    cur_i_d      = cur_i_q;
    cur_j_d      = cur_j_q;
    min_idx_d    = min_idx_q;
    swap_count_d = swap_count_q;
    desc_d       = desc_q;
    swap_pulse_d = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (load) begin
          for (int k = 0; k < N; k++) heights_d[k] = in_data[k*W +: W];
          state_d = StIdle;
        end else if (start) begin
          state_d      = StScan;
          cur_i_d      = '0;
          min_idx_d    = '0;
          cur_j_d      = IW'(1);
          swap_count_d = '0;
          desc_d       = desc;
        end
      end
      StScan: begin
        if (tick) begin
          if (better) min_idx_d = cur_j_q;
          if (cur_j_q == IW'(N - 1)) state_d = StSwap;
          else                       cur_j_d = cur_j_q + IW'(1);
        end
      end
      StSwap: begin
        if (tick) begin
          if (min_idx_q != cur_i_q) begin
            heights_d[cur_i_q]   = heights_q[min_idx_q];
            heights_d[min_idx_q] = heights_q[cur_i_q];
            swap_pulse_d         = 1'b1;
            if (swap_count_q != '1) swap_count_d = swap_count_q + SwapCntW'(1);
          end
          if (cur_i_q == IW'(N - 2)) begin
            state_d = StDone;
          end else begin
            cur_i_d   = cur_i_q + IW'(1);
            min_idx_d = cur_i_q + IW'(1);
            cur_j_d   = cur_i_q + IW'(2);
            state_d   = StScan;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StScan) || (state_d == StSwap);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      for (int k = 0; k < N; k++) heights_q[k] <= '0;
      cur_i_q      <= '0;
      cur_j_q      <= '0;
      min_idx_q    <= '0;
      swap_count_q <= '0;
      desc_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      swap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      heights_q    <= heights_d;
      cur_i_q      <= cur_i_d;
      cur_j_q      <= cur_j_d;
      min_idx_q    <= min_idx_d;
      swap_count_q <= swap_count_d;
      desc_q       <= desc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      swap_pulse_q <= swap_pulse_d;
    end
  end

  always_comb begin
    heights = '0;
    for (int k = 0; k < N; k++) heights[k*W +: W] = heights_q[k];
  end

  assign cur_i      = cur_i_q;
  assign cur_j      = cur_j_q;
  assign min_idx    = min_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign swap_pulse = swap_pulse_q;
  assign swap_count = swap_count_q;

endmodule

// File: tb/tb_select_sort_engine.sv
// Directed bench for select_sort_engine with N=5, W=7, DELAY=4.
module tb_select_sort_engine;

  localparam int unsigned N     = 5;
  localparam int unsigned W     = 7;
  localparam int unsigned DELAY = 4;
  localparam int unsigned IW    = $clog2(N);

  logic           clk = 1'b0;
  logic           reset, load, start, desc, auto_run, step;
  logic [N*W-1:0] in_data;
  logic [N*W-1:0] heights;
  logic [IW-1:0]  cur_i, cur_j, min_idx;
  logic           busy, done, swap_pulse;
  logic [7:0]     swap_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cycles, pulses;

  select_sort_engine #(
    .N    (N),
    .W    (W),
    .DELAY(DELAY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .in_data   (in_data),
    .start     (start),
    .desc      (desc),
    .auto_run  (auto_run),
    .step      (step),
    .heights   (heights),
    .cur_i     (cur_i),
    .cur_j     (cur_j),
    .min_idx   (min_idx),
    .busy      (busy),
    .done      (done),
    .swap_pulse(swap_pulse),
    .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Bar 0 is the first argument and sits in the least significant field.
  function automatic logic [N*W-1:0] pack(input int unsigned a, b, c, d, e);
    return {W'(e), W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // All tasks begin and end just after a falling edge.
  task automatic pulse_load(input logic [N*W-1:0] v);
    in_data = v;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic pulse_start(input logic d);
    desc  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(output int cyc, output int pul);
    cyc = 0;
    pul = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (swap_pulse) pul++;
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; desc = 1'b0;
    auto_run = 1'b1; step = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_heights", heights, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_swap_count", swap_count, 0);
    check("rst_idx", {cur_i, cur_j, min_idx}, 0);

    // Scenario 1: ascending, auto mode
    pulse_load(pack(50, 10, 40, 20, 30));
    check("s1_load", heights, pack(50, 10, 40, 20, 30));
    pulse_start(1'b0);
    check("s1_busy_rise", busy, 1);
    check("s1_start_idx", {cur_i, cur_j, min_idx}, {3'd0, 3'd1, 3'd0});
    wait_done(cycles, pulses);
    check("s1_latency", cycles, 56);
    check("s1_pulses", pulses, 4);
    check("s1_heights", heights, pack(10, 20, 30, 40, 50));
    check("s1_swap_count", swap_count, 4);
    check("s1_busy_end", busy, 0);
    repeat (5) @(negedge clk);
    check("s1_done_hold", done, 1);

    // Scenario 2: already sorted
    pulse_load(pack(10, 20, 30, 40, 50));
    check("s2_load_clears_done", done, 0);
    pulse_start(1'b0);
    wait_done(cycles, pulses);
    check("s2_done", done, 1);
    check("s2_latency", cycles, 56);
    check("s2_pulses", pulses, 0);
    check("s2_swap_count", swap_count, 0);
    check("s2_heights", heights, pack(10, 20, 30, 40, 50));

    // Scenario 3: descending
    pulse_load(pack(50, 10, 40, 20, 30));
    pulse_start(1'b1);
    wait_done(cycles, pulses);
    check("s3_heights", heights, pack(50, 40, 30, 20, 10));
    check("s3_swap_count", swap_count, 2);

    // Scenario 6: ties must not move the running minimum
    pulse_load(pack(3, 3, 1, 3, 1));
    pulse_start(1'b0);
    wait_done(cycles, pulses);
    check("s6_heights", heights, pack(1, 1, 3, 3, 3));
    check("s6_swap_count", swap_count, 2);

    // Scenario 4: step mode, frozen without steps, loads ignored while busy
    auto_run = 1'b0;
    pulse_load(pack(50, 10, 40, 20, 30));
    pulse_start(1'b0);
    repeat (1000) @(negedge clk);
    check("s4_frozen_idx", {cur_i, cur_j, min_idx}, {3'd0, 3'd1, 3'd0});
    check("s4_frozen_busy", busy, 1);
    check("s4_frozen_heights", heights, pack(50, 10, 40, 20, 30));
    pulse_load(pack(1, 2, 3, 4, 5));
    check("s4_load_ignored", heights, pack(50, 10, 40, 20, 30));
    repeat (3) pulse_step();
    check("s4_after3_cur_j", cur_j, 4);
    check("s4_after3_min", min_idx, 1);
    repeat (10) pulse_step();
    check("s4_after13_done", done, 0);
    pulse_step();
    check("s4_after14_done", done, 1);
    check("s4_heights", heights, pack(10, 20, 30, 40, 50));
    check("s4_swap_count", swap_count, 4);

    // Scenario 5: reset on the 3rd scan tick, then load+start together
    pulse_load(pack(50, 10, 40, 20, 30));
    pulse_start(1'b0);
    repeat (2) pulse_step();
    step  = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    step  = 1'b0;
    reset = 1'b0;
    check("s5_rst_heights", heights, 0);
    check("s5_rst_flags", {busy, done, swap_pulse}, 0);
    check("s5_rst_idx", {cur_i, cur_j, min_idx}, 0);
    check("s5_rst_swap_count", swap_count, 0);
    in_data = pack(5, 4, 3, 2, 1);
    load    = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    start   = 1'b0;
    check("s5_load_wins", heights, pack(5, 4, 3, 2, 1));
    repeat (3) @(negedge clk);
    check("s5_start_dropped", {busy, cur_j}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/select_sort_engine.md
SELECT_SORT_ENGINE -- requirements
Module: select_sort_engine

Interface
REQ-001 Parameter N, default 5: number of bars to sort; legal range 2..32.
REQ-002 Parameter W, default 7: height width in bits.
REQ-003 Parameter DELAY, default 50000000: clk cycles per auto-mode step; legal range >= 1.
REQ-004 Parameter IW, default $clog2(N): index width, derived, not overridden.
REQ-005 clk  in  1  system clock (100 MHz board clock); the block uses this one clock only.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 load  in  1  pulse; capture in_data into the height array.
REQ-008 in_data  in  N*W  initial heights, with bar k at bits [k*W +: W].
REQ-009 start  in  1  pulse; begin a sort pass sequence.
REQ-010 desc  in  1  0 = ascending, 1 = descending; sampled on the accepted start.
REQ-011 auto_run  in  1  1 = step every DELAY cycles; 0 = step on each step pulse.
REQ-012 step  in  1  single-step pulse; used only when auto_run = 0.
REQ-013 heights  out  N*W  current array, in the same packing as in_data.
REQ-014 cur_i, cur_j, min_idx  out  IW each  pass index, scan index and current minimum/maximum index, for display highlighting.
REQ-015 busy  out  1  high while in SCAN or SWAP.
REQ-016 done  out  1  high in DONE until the next load or reset.
REQ-017 swap_pulse  out  1  one-cycle pulse when an exchange is committed.
REQ-018 swap_count  out  8  number of exchanges committed since the last accepted start; saturates at 255.

Function
REQ-019 States: IDLE, SCAN, SWAP, DONE.
REQ-020 The block SHALL derive an internal tick. In auto mode, tick fires when the delay counter equals DELAY-1; the counter then clears. In step mode, tick equals step.
REQ-021 The delay counter SHALL clear on the accepted start.
REQ-022 In IDLE or DONE, load SHALL write in_data into heights on the next edge, go to IDLE and clear done.
REQ-023 In IDLE or DONE, start SHALL go to SCAN and set cur_i=0, min_idx=0, cur_j=1 and swap_count=0; busy is high on the following cycle.
REQ-024 If load and start are asserted in the same cycle, load SHALL win and start SHALL be dropped.
REQ-025 load and start SHALL be ignored while busy.
REQ-026 Each SCAN tick SHALL compare heights[cur_j] with heights[min_idx].
REQ-027 On that comparison, min_idx SHALL take cur_j only if it is strictly smaller (ascending) or strictly larger (descending).
REQ-028 On the same SCAN tick: if cur_j = N-1, go to SWAP; otherwise cur_j increments.
REQ-029 On a SWAP tick with min_idx != cur_i, the block SHALL exchange heights[cur_i] and heights[min_idx], pulse swap_pulse and increment swap_count.
REQ-030 On a SWAP tick with min_idx = cur_i, there is no exchange and no pulse.
REQ-031 On the same SWAP tick: if cur_i = N-2, go to DONE; otherwise cur_i increments, min_idx takes the new cur_i, cur_j takes cur_i+2, and the state returns to SCAN.
REQ-032 Each sort SHALL take exactly N(N-1)/2 SCAN ticks plus N-1 SWAP ticks; done rises on the edge of the final SWAP tick.
REQ-033 Without ticks, state and all outputs SHALL hold; step pulses in auto mode SHALL have no effect.
REQ-034 Changing auto_run mid-sort SHALL take effect on the next cycle; the delay counter SHALL be kept.
REQ-035 Comparisons SHALL be unsigned over W bits.

Reset
REQ-036 On reset the block SHALL go to IDLE, with heights, cur_i, cur_j, min_idx, swap_count, the delay counter, busy, done and swap_pulse all at 0.
REQ-037 Reset SHALL abort a sort in progress with no partial exchange.

Structure
REQ-038 Package sort_pkg SHALL hold the state enum (IDLE/SCAN/SWAP/DONE) and the swap_count width constant.
REQ-039 A single sub-module, step_timer (parameter DELAY; inputs clk, reset, clear, auto_run, step; output tick), SHALL generate the tick.

Verification
REQ-040 Setup for all scenarios: N=5, W=7, DELAY=4.
REQ-041 Scenario 1: load [50,10,40,20,30], ascending, auto -> heights [10,20,30,40,50], swap_count=4, done 56 cycles after busy rises.
REQ-042 Scenario 2: load [10,20,30,40,50], ascending -> swap_count=0, no swap_pulse, array unchanged, done set.
REQ-043 Scenario 3: load [50,10,40,20,30], desc=1 -> heights [50,40,30,20,10].
REQ-044 Scenario 4: step mode with no step pulses for 1000 cycles -> state and outputs frozen; then 14 step pulses -> done.
REQ-045 Scenario 5: reset asserted during the 3rd SCAN tick -> all outputs 0 and IDLE next cycle; load and start in the same cycle -> only the load takes effect.
REQ-046 Scenario 6: load [3,3,1,3,1], ascending -> [1,1,3,3,3]; only strict comparisons move min_idx.
